// File: rtl/tmds_period_sequencer.sv
// Pixel-clock h/v timing generator and TMDS period scheduler (CTRL/PREAMBLE/GUARD/VIDEO).
// Define TMDS_PREAMBLE_EN for HDMI preamble/guard periods; leave undefined for plain DVI.
module tmds_period_sequencer #(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter int SYNC_POL = 1
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        en_in,
    output logic [10:0] hcount_out,
    output logic [9:0]  vcount_out,
    output logic        ve_out,
    output logic [1:0]  ctl0_out,
    output logic [1:0]  ctl1_out,
    output logic [1:0]  ctl2_out,
    output logic        guard_out,
    output logic        new_frame_out
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] HS_LO  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_HI  = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] PRE_LO = 11'(H_TOTAL - 10);
    localparam logic [10:0] PRE_HI = 11'(H_TOTAL - 3);
    localparam logic [10:0] GRD_LO = 11'(H_TOTAL - 2);
    localparam logic [9:0]  V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0]  VS_LO  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_HI  = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic        POL    = (SYNC_POL != 0);

`ifdef TMDS_PREAMBLE_EN
    generate
        if (H_BP < 10) begin : g_bp_check
            $error("H_BP must be >= 10 to hold preamble and guard band");
        end
    endgenerate
`endif

    // State bits double as registered outputs: [2]=ve, [1]=guard, [0]=CTL0
    typedef enum logic [2:0] {
        CTRL     = 3'b000,
        PREAMBLE = 3'b001,
        GUARD    = 3'b010,
        VIDEO    = 3'b100
    } state_t;

    state_t      state_q, state_d;
    logic [10:0] h_d;
    logic [9:0]  v_d;
    logic        hs_d, vs_d, nla_d;
    logic [1:0]  ctl0_d;

    always_comb begin
        h_d      = hcount_out + 11'd1;
        v_d      = vcount_out;
        state_d  = CTRL;
        if (hcount_out == H_LAST) begin
            h_d = 11'd0;
            v_d = (vcount_out == V_LAST) ? 10'd0 : vcount_out + 10'd1;
        end
        nla_d  = (v_d == V_LAST) || ((v_d + 10'd1) < V_ACT);
        hs_d   = (h_d >= HS_LO) && (h_d < HS_HI);
        vs_d   = (v_d >= VS_LO) && (v_d < VS_HI);
        if ((h_d < H_ACT) && (v_d < V_ACT)) begin
            state_d = VIDEO;
`ifdef TMDS_PREAMBLE_EN
        end else if (nla_d && (h_d >= PRE_LO) && (h_d <= PRE_HI)) begin
            state_d = PREAMBLE;
        end else if (nla_d && (h_d >= GRD_LO)) begin
            state_d = GUARD;
`endif
        end
        ctl0_d = {~(vs_d ^ POL), ~(hs_d ^ POL)};
        if (state_d == VIDEO) begin
            ctl0_d = 2'b00;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            hcount_out    <= H_ACT;
            vcount_out    <= V_LAST;
            state_q       <= CTRL;
            ctl0_out      <= {~POL, ~POL};
            new_frame_out <= 1'b0;
        end else if (en_in) begin
            hcount_out    <= h_d;
            vcount_out    <= v_d;
            state_q       <= state_d;
            ctl0_out      <= ctl0_d;
            new_frame_out <= (h_d == 11'd0) && (v_d == 10'd0);
        end
    end

    assign ve_out   = state_q[2];
    assign ctl2_out = 2'b00;

`ifdef TMDS_PREAMBLE_EN
    assign guard_out = state_q[1];
    assign ctl1_out  = {1'b0, state_q[0]};
`else
    logic dvi_unused;
    assign dvi_unused = ^state_q[1:0];
    assign guard_out  = 1'b0;
    assign ctl1_out   = 2'b00;
`endif

    // nla_d is only consumed by the preamble/guard decode
    logic nla_unused;
    assign nla_unused = nla_d;

endmodule

// File: doc/tmds_period_sequencer.md
Name: tmds_period_sequencer

Overview:
- Video timing generator and period scheduler for the three-channel TMDS encoder bank.
- Runs pixel-clock h/v counters and decides, per pixel, whether each encoder sees:
  - a control period (sync/CTL code),
  - an HDMI video preamble,
  - a video leading guard band,
  - active video.
- Drives every encoder's ve_in/control_in and the guard-band symbol mux, and gives the pixel source its coordinates.

Parameters:
- H_ACTIVE, 1280, active pixels per line
- H_FP, 110, horizontal front porch (pixels)
- H_SYNC, 40, hsync width (pixels)
- H_BP, 220, horizontal back porch (pixels); must be >= 10
- V_ACTIVE, 720, active lines per frame
- V_FP, 5, vertical front porch (lines)
- V_SYNC, 5, vsync width (lines)
- V_BP, 20, vertical back porch (lines)
- SYNC_POL, 1, 1 = syncs active-high, 0 = active-low

Ports:
- clk_in  input  1  pixel clock
- rst_in  input  1  asynchronous active-high reset
- en_in  input  1  pixel advance enable; all state holds when 0
- hcount_out  output  11  current pixel x
- vcount_out  output  10  current line y
- ve_out  output  1  to all encoders' ve_in; 1 = active video
- ctl0_out  output  2  channel 0 control_in = {vsync, hsync}
- ctl1_out  output  2  channel 1 control_in = {CTL1, CTL0}
- ctl2_out  output  2  channel 2 control_in = {CTL3, CTL2}
- guard_out  output  1  1 = downstream mux substitutes guard-band symbols
- new_frame_out  output  1  one-cycle pulse at (0,0)

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Horizontal regions, h = 0..H_TOTAL-1:
  - active: [0, H_ACTIVE)
  - front porch next, then sync: [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC)
  - back porch last.
- Vertical regions use the same ordering.
- Counters:
  - h increments on each en_in cycle; at H_TOTAL-1 it wraps to 0 and v increments.
  - v wraps V_TOTAL-1 to 0.
  - en_in=0 freezes counters and all outputs.
- All outputs are registered and mutually coherent: in any cycle, every output describes the pixel at (hcount_out, vcount_out).
- Per-line FSM states: CTRL, PREAMBLE, GUARD, VIDEO.
  - VIDEO when h < H_ACTIVE and v < V_ACTIVE.
  - PREAMBLE when h in [H_TOTAL-10, H_TOTAL-3] and the next line is active (v == V_TOTAL-1 or v+1 < V_ACTIVE).
  - GUARD when h in [H_TOTAL-2, H_TOTAL-1] under the same next-line condition.
  - CTRL otherwise.
- Outputs per state:
  - VIDEO: ve_out=1, guard_out=0, ctl*_out = don't-care but driven 00.
  - CTRL: ve_out=0, guard_out=0, ctl1_out=00, ctl2_out=00.
  - PREAMBLE: ve_out=0, guard_out=0, ctl1_out=01 (CTL0=1), ctl2_out=00.
  - GUARD: ve_out=0, guard_out=1, ctl1/ctl2 = 00.
- ctl0_out = {vsync, hsync} in every non-VIDEO state, SYNC_POL applied; inactive level = ~SYNC_POL.
- new_frame_out = 1 exactly in the cycle where hcount_out=0 and vcount_out=0.
- Reset (asynchronous, any time, including mid-line):
  - Internal counters go to h=H_ACTIVE, v=V_TOTAL-1.
  - Outputs:
    - hcount_out=H_ACTIVE, vcount_out=V_TOTAL-1
    - ve_out=0, guard_out=0, new_frame_out=0
    - ctl0_out={~SYNC_POL,~SYNC_POL}, ctl1_out=00, ctl2_out=00
  - After release, the first frame starts with a full preamble and guard band; no partial active line is ever emitted.
- Boundary rules:
  - Vsync changes only at h=0 line boundaries.
  - Preamble and guard must lie entirely inside the back porch; H_BP < 10 is an elaboration error.

Optional Feature:
- Macro: TMDS_PREAMBLE_EN.
- Defined: HDMI behaviour as above, with PREAMBLE/GUARD states.
- Undefined (plain DVI): PREAMBLE/GUARD states do not exist; those pixels are CTRL, guard_out is tied 0, ctl1_out and ctl2_out are constant 00, and the H_BP >= 10 check is removed.
- Counters, sync and ve_out are identical in both builds.

Test Plan (bench params H_ACTIVE=16, H_FP=4, H_SYNC=4, H_BP=12, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=2, SYNC_POL=1 → H_TOTAL=36, V_TOTAL=8):
- Reset release, en_in=1 → first output cycle (h=16, v=7); ctl1_out=01 at h=26..33 of v=7; guard_out=1 at h=34..35; new_frame_out=1 and ve_out=1 at (0,0).
- Line 0 sweep → ve_out=1 for h=0..15 only; ctl0_out=01 for h=20..23; ctl0_out=00 elsewhere in blanking.
- Line 3 (last active) → no preamble or guard at h=26..35 of v=3..6; ve_out=0 for all h on v=4..7; ctl0_out[1]=1 for all h on v=5.
- en_in toggled 1/0 alternately → counters advance every second cycle; outputs identical sequence to continuous run, just stretched 2×.
- rst_in asserted at (h=5, v=2) with ve_out=1 → ve_out=0 immediately (asynchronous); after release the sequence restarts from (16, 7) with the full preamble.
- Build without TMDS_PREAMBLE_EN → guard_out constant 0 and ctl1_out constant 00 over 2 frames; ve_out/ctl0_out waveforms match the default build.
